// File: rtl/imm_decode_stage.sv
// Registered immediate decoder: opcode-inferred format, sign-extended imm,
// pc+imm target, valid/ready pipeline with a 2-entry skid and flush.
module imm_decode_stage #(
  parameter int XLEN      = 32,
  parameter bit RV64_W_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  localparam bit W_OK = RV64_W_EN && (XLEN == 64);

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  entry_t dec;
  entry_t main_q;
  entry_t skid_q;
  logic   skid_valid;

  logic [6:0]        opc;
  logic              is_i, is_s, is_b, is_u, is_j, is_r;
  logic [2:0]        fmt;
  logic signed [31:0] imm32;
  logic              accept;
  logic              load;

  assign opc  = in_inst[6:0];
  assign is_i = (opc inside {7'b0000011, 7'b0010011, 7'b1100111,
                             7'b0001111, 7'b1110011})
              || (W_OK && opc == 7'b0011011);
  assign is_s = opc == 7'b0100011;
  assign is_b = opc == 7'b1100011;
  assign is_u = opc inside {7'b0110111, 7'b0010111};
  assign is_j = opc == 7'b1101111;
  assign is_r = opc == 7'b0110011;

  always_comb begin
    fmt   = FMT_X;
    imm32 = '0;
    unique case (1'b1)
      is_i: begin
        fmt   = FMT_I;
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      is_s: begin
        fmt   = FMT_S;
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      is_b: begin
        fmt   = FMT_B;
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
      end
      is_u: begin
        fmt   = FMT_U;
        imm32 = {in_inst[31:12], 12'b0};
      end
      is_j: begin
        fmt   = FMT_J;
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      end
      is_r: fmt = FMT_R;
      default: ;
    endcase
    dec.inst = in_inst;
    dec.pc   = in_pc;
    dec.imm  = XLEN'(imm32);
    dec.fmt  = fmt;
  end

  // Ready comes only from the skid flag, so no out_ready->in_ready path.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign load     = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      out_valid <= skid_valid | accept;
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_inst   = main_q.inst;
  assign out_pc     = main_q.pc;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_target = main_q.pc + main_q.imm;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: XLEN=32 plus two XLEN=64
// builds (OP-IMM-32 enabled/disabled) driven by the same stream.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_inst, a_out_pc, a_out_imm, a_out_target;
  logic [2:0]  a_out_fmt;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_inst;
  logic [63:0] b_out_pc, b_out_imm, b_out_target;
  logic [2:0]  b_out_fmt;
  logic        c_in_ready, c_out_valid;
  logic [31:0] c_out_inst;
  logic [63:0] c_out_pc, c_out_imm, c_out_target;
  logic [2:0]  c_out_fmt;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .RV64_W_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_inst(a_out_inst), .out_pc(a_out_pc), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_target(a_out_target)
  );

  imm_decode_stage #(.XLEN(64), .RV64_W_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_inst(b_out_inst), .out_pc(b_out_pc), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_target(b_out_target)
  );

  imm_decode_stage #(.XLEN(64), .RV64_W_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .out_inst(c_out_inst), .out_pc(c_out_pc), .out_imm(c_out_imm),
    .out_fmt(c_out_fmt), .out_target(c_out_target)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [2:0]  fa, fb, fc;
    logic [63:0] ia, ib, ic;
    logic [63:0] ta, tb, tc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   pops = 0;

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h1B,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
                           7'h1B, 7'h7F};

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] i, input bit w_ok,
                                  output logic [2:0] f, output longint imm);
    f   = 3'd7;
    imm = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        f = 3'd1; imm = longint'($signed(i[31:20]));
      end
      7'h1B: if (w_ok) begin
        f = 3'd1; imm = longint'($signed(i[31:20]));
      end
      7'h23: begin
        f = 3'd2; imm = longint'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        f = 3'd3;
        imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        f = 3'd4; imm = longint'($signed(i[31:12])) * 4096;
      end
      7'h6F: begin
        f = 3'd5;
        imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h33: f = 3'd0;
      default: ;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [31:0] i,
                                    input logic [63:0] pc);
    exp_t   e;
    longint v;
    logic [63:0] m32 = 64'hFFFF_FFFF;
    e.inst = i;
    e.pc   = pc;
    ref_dec(i, 1'b0, e.fa, v);
    e.ia = 64'(v) & m32;
    e.ta = (pc + 64'(v)) & m32;
    ref_dec(i, 1'b1, e.fb, v);
    e.ib = 64'(v);
    e.tb = pc + 64'(v);
    ref_dec(i, 1'b0, e.fc, v);
    e.ic = 64'(v);
    e.tc = pc + 64'(v);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 14);
    logic [6:0] op = (k < 14) ? ops[k] : r[6:0];
    return {r[31:7], op};
  endfunction

  // Monitor: compare against the scoreboard head; retire on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit   v = exp_q.size() > 0;
      automatic exp_t e;
      chk("a_valid", 64'(a_out_valid), 64'(v));
      chk("b_valid", 64'(b_out_valid), 64'(v));
      chk("c_valid", 64'(c_out_valid), 64'(v));
      chk("a_ready", 64'(a_in_ready), 64'(exp_q.size() < 2));
      chk("b_ready", 64'(b_in_ready), 64'(exp_q.size() < 2));
      chk("c_ready", 64'(c_in_ready), 64'(exp_q.size() < 2));
      if (v) begin
        e = exp_q[0];
        if (a_out_valid) begin
          chk("a_inst", 64'(a_out_inst), 64'(e.inst));
          chk("a_pc", 64'(a_out_pc), e.pc & 64'hFFFF_FFFF);
          chk("a_fmt", 64'(a_out_fmt), 64'(e.fa));
          chk("a_imm", 64'(a_out_imm), e.ia);
          chk("a_target", 64'(a_out_target), e.ta);
        end
        if (b_out_valid) begin
          chk("b_inst", 64'(b_out_inst), 64'(e.inst));
          chk("b_fmt", 64'(b_out_fmt), 64'(e.fb));
          chk("b_imm", b_out_imm, e.ib);
          chk("b_target", b_out_target, e.tb);
        end
        if (c_out_valid) begin
          chk("c_pc", c_out_pc, e.pc);
          chk("c_fmt", 64'(c_out_fmt), 64'(e.fc));
          chk("c_imm", c_out_imm, e.ic);
          chk("c_target", c_out_target, e.tc);
        end
        if (!flush && out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  // Drives one cycle; pushes the expected entry when the model accepts.
  task automatic cycle(input bit v, input logic [31:0] inst,
                       input logic [63:0] pc, input bit rdy,
                       input bit fl, output bit acc);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    acc = v && !fl && (exp_q.size() < 2);
    @(posedge clk);
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back(make_exp(inst, pc));
    #1;
  endtask

  task automatic step(input bit v, input logic [31:0] inst,
                      input logic [63:0] pc, input bit rdy, input bit fl);
    bit acc;
    cycle(v, inst, pc, rdy, fl, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  logic [31:0] sw_inst [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7,
                               32'h001000EF, 32'h00000033, 32'h0000007F};
  logic [2:0]  sw_fmt  [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
  logic [31:0] sw_imm  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                               32'h00000800, 32'h0, 32'h0};
  logic [31:0] sw_tgt  [6] = '{32'h000000FF, 32'h000000FC, 32'h12345100,
                               32'h00000900, 32'h100, 32'h100};

  initial begin
    bit acc;
    int base;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_ready", 64'(a_in_ready), 64'd1);
    chk("rst_a_imm", 64'(a_out_imm), 64'd0);
    chk("rst_a_target", 64'(a_out_target), 64'd0);
    chk("rst_b_inst", 64'(b_out_inst), 64'd0);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      step(1'b1, sw_inst[k], 64'h100, 1'b1, 1'b0);
      chk("sweep_fmt", 64'(a_out_fmt), 64'(sw_fmt[k]));
      chk("sweep_imm", 64'(a_out_imm), 64'(sw_imm[k]));
      chk("sweep_target", 64'(a_out_target), 64'(sw_tgt[k]));
    end
    step(1'b1, 32'hFFF0009B, 64'h100, 1'b1, 1'b0);
    chk("w_b_fmt", 64'(b_out_fmt), 64'd1);
    chk("w_b_imm", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w_c_fmt", 64'(c_out_fmt), 64'd7);
    chk("w_a_fmt", 64'(a_out_fmt), 64'd7);
    step(1'b1, 32'h02000063, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0);
    chk("wrap_b_target", b_out_target, 64'h10);
    chk("wrap_a_target", 64'(a_out_target), 64'h10);
    drain();

    // Backpressure: A held, B in skid, C refused until space opens.
    step(1'b1, 32'h00A00093, 64'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 64'h204, 1'b0, 1'b0);
    step(1'b1, 32'h00C00093, 64'h208, 1'b0, 1'b0);
    chk("bp_ready", 64'(a_in_ready), 64'd0);
    chk("bp_hold", 64'(a_out_imm), 64'hA);
    acc = 1'b0;
    for (int n = 0; n < 5 && !acc; n++)
      cycle(1'b1, 32'h00C00093, 64'h208, 1'b1, 1'b0, acc);
    chk("bp_c_accepted", 64'(acc), 64'd1);
    drain();

    // Flush while full, with a concurrent input.
    step(1'b1, 32'h01100093, 64'h300, 1'b0, 1'b0);
    step(1'b1, 32'h01200093, 64'h304, 1'b0, 1'b0);
    step(1'b1, 32'h01300093, 64'h308, 1'b0, 1'b1);
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_ready", 64'(a_in_ready), 64'd1);
    step(1'b1, 32'h01400093, 64'h30C, 1'b0, 1'b0);
    step(1'b1, 32'h01500093, 64'h310, 1'b1, 1'b1);
    chk("fl1_valid", 64'(b_out_valid), 64'd0);
    drain();

    // Reset mid-stream with two entries held.
    step(1'b1, 32'h02100093, 64'h400, 1'b0, 1'b0);
    step(1'b1, 32'h02200093, 64'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(a_out_valid), 64'd0);
    chk("mrst_ready", 64'(a_in_ready), 64'd1);
    chk("mrst_b_valid", 64'(b_out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 32'h02300093, 64'h408, 1'b1, 1'b0);
    chk("post_rst_valid", 64'(a_out_valid), 64'd1);
    chk("post_rst_inst", 64'(a_out_inst), 64'h02300093);
    drain();

    // Throughput: 100 back-to-back inputs with out_ready held high.
    base = pops;
    for (int n = 0; n < 100; n++)
      step(1'b1, rand_inst(), {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("thru_count", 64'(pops - base), 64'd100);

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, rand_inst(), {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
